// File: rtl/i2c_master.sv
// i2c_master: single-byte open-drain I2C master; define I2C_MASTER_STRETCH_EN to honour target clock stretching
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        scl,
    inout  wire        sda
);
    typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP} state_t;
    state_t state, state_n;
    logic [9:0] cnt;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [15:0] sh;
    logic rw_q, ack_bit, hold, tick, sample, bit_end, scl_oe, sda_oe;
`ifdef I2C_MASTER_STRETCH_EN
    assign hold = phase == 2'd2 && scl == 1'b0;
`else
    assign hold = 1'b0;
`endif
    assign tick = state != IDLE && !hold && cnt == 10'(CLK_DIV - 1);
    assign sample = tick && phase == 2'd2;
    assign bit_end = tick && phase == 2'd3;
    assign busy = state != IDLE;
    assign scl_oe = !(state == IDLE || state == START) && !phase[1];
    assign sda_oe = state == START || state == STOP || ((state == ADDR || state == WRITE) && !sh[15]);
    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? START : IDLE;
            START:     if (tick && phase == 2'd1) state_n = ADDR;
            ADDR:      if (bit_end && bit_cnt == 3'd7) state_n = ADDR_ACK;
            ADDR_ACK:  if (bit_end) state_n = ack_bit ? STOP : rw_q ? READ : WRITE;
            WRITE:     if (bit_end && bit_cnt == 3'd7) state_n = WRITE_ACK;
            WRITE_ACK: if (bit_end) state_n = STOP;
            READ:      if (bit_end && bit_cnt == 3'd7) state_n = READ_NACK;
            READ_NACK: if (bit_end) state_n = STOP;
            STOP:      if (bit_end) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    // sh holds {addr, rw, wr_data} for shifting out, and collects read bits in its low byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            rw_q    <= 1'b0;
            ack_bit <= 1'b0;
            rd_data <= '0;
            ack_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state == STOP && state_n == IDLE;
            if (state == IDLE) begin
                cnt     <= '0;
                phase   <= '0;
                bit_cnt <= '0;
                if (start) begin
                    sh      <= {dev_addr, rw, wr_data};
                    rw_q    <= rw;
                    ack_err <= 1'b0;
                end
            end else if (!hold) begin
                cnt <= tick ? '0 : cnt + 10'd1;
                if (tick) phase <= (state == START && phase == 2'd1) ? 2'd0 : phase + 2'd1;
                if (bit_end && (state == ADDR || state == WRITE || state == READ)) bit_cnt <= bit_cnt + 3'd1;
                if (bit_end && (state == ADDR || state == WRITE)) sh <= {sh[14:0], 1'b0};
                if (sample) begin
                    ack_bit <= sda;
                    if (state == READ) sh <= {sh[14:0], sda};
                    if ((state == ADDR_ACK || state == WRITE_ACK) && sda) ack_err <= 1'b1;
                end
                if (bit_end && state == READ && bit_cnt == 3'd7) rd_data <= sh[7:0];
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench with a behavioural I2C target decoding and driving the bus
module tb_i2c_master;
    localparam int C = 4;
    logic clk = 0, reset_n = 0, start = 0, rw = 0;
    logic [6:0] dev_addr = 0;
    logic [7:0] wr_data = 0;
    logic [7:0] rd_data;
    logic busy, done, ack_err;
    wire scl, sda;
    logic tgt_sda_low = 0, tgt_scl_low = 0;
    pullup (scl);
    pullup (sda);
    assign scl = tgt_scl_low ? 1'b0 : 1'bz;
    assign sda = tgt_sda_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(C)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .dev_addr(dev_addr),
        .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] data_b;
        logic       is_read;
        logic       err;
        int         nbytes;
        int         len;
        int         accept;
    } exp_t;
    exp_t sb[$];
    exp_t me;
    int checks = 0, passed = 0, cyc = 0, done_cnt = 0;
    logic [7:0] last_rd = 0;

    logic ack_addr = 1, ack_data = 1, stretch_req = 0;
    logic [7:0] tgt_rd = 0, tsh = 0;
    logic [7:0] obs[$];
    logic prev_scl = 1, prev_sda = 1, tgt_rw = 0, addr_acked = 0, master_nack = 0, stretch_sda = 0;
    logic s_scl, s_sda;
    int bitn = 0, byte_idx = 0, stretch_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // target: decodes START/bits on SCL rise, drives ACK/read data after SCL fall
    always @(negedge clk) begin
        s_scl = scl;
        s_sda = sda;
        if (stretch_cnt > 0) begin
            stretch_cnt--;
            if (stretch_cnt == 0) begin
                tgt_scl_low = 0;
                chk("stretch_sda_stable", s_sda, stretch_sda);
            end
        end
        if (prev_scl && s_scl && prev_sda && !s_sda) begin
            bitn = 0;
            byte_idx = 0;
            addr_acked = 0;
            obs.delete();
        end else if (!prev_scl && s_scl) begin
            if (bitn < 8) tsh = {tsh[6:0], s_sda};
            bitn++;
            if (bitn == 8) begin
                obs.push_back(tsh);
                if (byte_idx == 0) tgt_rw = tsh[0];
            end
            if (bitn == 9 && byte_idx == 0) addr_acked = !s_sda;
            if (bitn == 9 && byte_idx == 1 && tgt_rw) master_nack = s_sda;
        end else if (prev_scl && !s_scl) begin
            if (bitn == 9) begin
                bitn = 0;
                byte_idx++;
            end
            tgt_sda_low = 0;
            if (bitn == 8) tgt_sda_low = byte_idx == 0 ? ack_addr : (byte_idx == 1 && !tgt_rw && ack_data);
            else if (byte_idx == 1 && tgt_rw && addr_acked && bitn < 8) tgt_sda_low = !tgt_rd[7-bitn];
            if (stretch_req && byte_idx == 1 && bitn == 3) begin
                tgt_scl_low = 1;
                stretch_cnt = 2 * C + 20;
                stretch_sda = s_sda;
                stretch_req = 0;
            end
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    end

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_done: done with empty scoreboard at cycle %0d", cyc);
            end else begin
                me = sb.pop_front();
                chk("ack_err", ack_err, me.err);
                chk("nbytes", obs.size(), me.nbytes);
                if (obs.size() > 0) chk("addr_byte", obs[0], me.addr_b);
                if (!me.is_read && me.nbytes == 2 && obs.size() > 1) chk("wr_byte", obs[1], me.data_b);
                if (me.is_read && !me.err) begin
                    last_rd = me.data_b;
                    chk("master_nack", master_nack, 1);
                end
                chk("rd_data", rd_data, last_rd);
                chk("length", cyc - me.accept, me.len);
            end
        end
    end

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input logic [7:0] rb,
                           input logic aa, input logic ad, input logic stretch, input logic poke);
        exp_t e;
        int n0, t;
        ack_addr = aa;
        ack_data = ad;
        tgt_rd = rb;
        stretch_req = stretch;
        @(negedge clk);
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        e.addr_b = {a, r};
        e.data_b = r ? rb : d;
        e.is_read = r;
        e.err = !aa || (!r && !ad);
        e.nbytes = aa ? 2 : 1;
        e.len = C * (6 + 36 * (aa ? 2 : 1)) + (stretch ? 20 : 0);
        e.accept = cyc + 1;
        sb.push_back(e);
        n0 = done_cnt;
        dev_addr = a;
        rw = r;
        wr_data = d;
        start = 1;
        @(negedge clk);
        start = 0;
        dev_addr = 7'($urandom);
        rw = 1'($urandom);
        wr_data = 8'($urandom);
        if (poke) begin
            repeat (100) @(negedge clk);
            dev_addr = ~a;
            rw = ~r;
            start = 1;
            @(negedge clk);
            start = 0;
        end
        t = 0;
        while (done_cnt == n0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == n0) begin
            checks++;
            $display("FAIL timeout: no done after %0d cycles", t);
        end
        repeat (5) @(negedge clk);
        chk("single_done", done_cnt, n0 + 1);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        reset_n = 1;
        repeat (3) @(negedge clk);

        run_txn(7'h50, 0, 8'hA5, 8'h00, 1, 1, 0, 0);
        run_txn(7'h50, 1, 8'h00, 8'h3C, 1, 1, 0, 0);
        run_txn(7'h50, 0, 8'hA5, 8'h00, 0, 1, 0, 0);
        run_txn(7'h2B, 0, 8'h96, 8'h00, 1, 0, 0, 0);
        run_txn(7'h13, 1, 8'h00, 8'hE7, 1, 1, 0, 1);

        ack_addr = 1;
        ack_data = 1;
        dev_addr = 7'h50;
        rw = 0;
        wr_data = 8'h00;
        start = 1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (!(byte_idx == 1 && bitn == 3) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        while (scl && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            $display("FAIL abort_wait: write bit 3 not reached after %0d cycles", t);
        end
        @(negedge clk);
        chk("pre_abort_sda", sda, 0);
        reset_n = 0;
        #1;
        chk("abort_scl", scl, 1);
        chk("abort_sda", sda, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rd_data", rd_data, 0);
        last_rd = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        run_txn(7'h50, 0, 8'h5A, 8'h00, 1, 1, 0, 0);

`ifdef I2C_MASTER_STRETCH_EN
        run_txn(7'h50, 0, 8'hC3, 8'h00, 1, 1, 1, 0);
`endif

        for (int i = 0; i < 20; i++)
            run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, 1'b0, 1'($urandom_range(0, 3) == 0));

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 250; clk cycles per quarter SCL period (legal range 2..1023).
REQ-002 SHALL provide port clk, input, 1; system clock, all logic rising-edge.
REQ-003 SHALL provide port reset_n, input, 1; asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1; request a single-byte transaction, sampled only while busy=0.
REQ-005 SHALL provide port rw, input, 1; transaction direction, 1=read, 0=write, captured with start.
REQ-006 SHALL provide port dev_addr, input, 7; target address, captured with start.
REQ-007 SHALL provide port wr_data, input, 8; write payload, captured with start.
REQ-008 SHALL provide port rd_data, output, 8; last byte read, held until the next read completes.
REQ-009 SHALL provide port busy, output, 1; high from the cycle after start is accepted until done.
REQ-010 SHALL provide port done, output, 1; single-cycle pulse when STOP completes.
REQ-011 SHALL provide port ack_err, output, 1; target NACKed the address or write byte, valid with done, held until the next start.
REQ-012 SHALL provide port scl, inout, 1; open-drain, driven 0 or released to Z, never driven 1.
REQ-013 SHALL provide port sda, inout, 1; open-drain, driven 0 or released to Z, never driven 1.

Function
REQ-014 SHALL divide each SCL bit period into 4 phases of CLK_DIV cycles: P0 SCL low, SDA updated; P1 SCL low; P2 SCL released; P3 SCL released, SDA sampled on the last cycle of P2.
REQ-015 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP.
REQ-016 IDLE: SCL and SDA released; start=1 captures inputs and moves to START on the next cycle.
REQ-017 START: with SCL released, SHALL pull SDA low for 2 phases, then pull SCL low and enter ADDR.
REQ-018 ADDR: SHALL shift out {dev_addr, rw} MSB first, 8 bits, with a 3-bit counter that wraps 7->0.
REQ-019 ADDR_ACK: SHALL release SDA; a sampled 0 goes to WRITE (rw=0) or READ (rw=1); a sampled 1 sets ack_err and goes to STOP.
REQ-020 WRITE: SHALL shift out the captured wr_data MSB first; then WRITE_ACK follows the same ACK rule and always proceeds to STOP.
REQ-021 READ: SHALL release SDA and shift the sampled bits into rd_data MSB first; rd_data SHALL update only after bit 0.
REQ-022 READ_NACK: SHALL release SDA (NACK) for one bit period, then go to STOP.
REQ-023 STOP: SHALL pull SDA low while SCL is low, release SCL, then release SDA 2 phases later; done pulses on the cycle the FSM returns to IDLE.
REQ-024 SHALL take start=1 while busy=1 without effect, with no queuing.
REQ-025 SHALL never change SDA while SCL is released except for the START and STOP edges.

Reset
REQ-026 On reset_n=0, SHALL immediately release scl and sda, and force state to IDLE, busy=0, done=0, ack_err=0, rd_data=8'h00, with counters cleared.
REQ-027 Reset asserted mid-transaction SHALL abort without generating STOP; the first start after release SHALL begin a clean START.

Configuration
REQ-028 Macro I2C_MASTER_STRETCH_EN defined: in P2, SHALL hold the phase counter while the scl input reads 0, so phase P3 begins only after the target releases SCL.
REQ-029 Macro I2C_MASTER_STRETCH_EN undefined: SHALL ignore the scl input, so phases are fixed length and a full transaction takes a constant number of cycles.

Verification
REQ-030 Write with CLK_DIV=4, dev_addr=7'h50, rw=0, wr_data=8'hA5, and the target ACKing both bytes -> SDA carries 0xA0 then 0xA5, done pulses once, ack_err=0.
REQ-031 Read with dev_addr=7'h50 and rw=1, the target ACKs the address and drives 8'h3C -> address byte 0xA1, master NACKs, rd_data=8'h3C at done.
REQ-032 Address NACK, with the target leaving SDA high in ADDR_ACK -> no data byte is sent, STOP is issued, done pulses with ack_err=1.
REQ-033 Reset during the 4th bit of WRITE -> scl and sda are Z within the same cycle as reset, busy=0; a following write of 8'h5A completes normally.
REQ-034 With I2C_MASTER_STRETCH_EN, the target holds SCL low for 20 cycles in the WRITE bit-3 P2 -> the data bit is stable throughout, the transaction lengthens by 20 cycles, and the result is correct.
REQ-035 start pulsed while busy=1 -> it is ignored, and exactly one done pulse occurs.
